// File: rtl/store_commit_buffer_if.sv
// Bundles the retire-side push port, status flags, memory write handshake and
// the load-conflict probe of store_commit_buffer. master = retire/memory side, slave = buffer.
interface store_commit_buffer_if #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64
);
  localparam int CW = $clog2(DEPTH + 1);

  logic              push;
  logic [ADDR_W-1:0] push_addr;
  logic [DATA_W-1:0] push_data;
  logic [3:0]        push_size;

  logic              full;
  logic              empty;
  logic [CW-1:0]     count;
  logic              overflow;

  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [7:0]        mem_wmask;
  logic              mem_ack;

  logic [ADDR_W-1:0] ld_addr;
  logic              ld_conflict;

  modport master (
    output push, push_addr, push_data, push_size, mem_ack, ld_addr,
    input  full, empty, count, overflow,
    input  mem_req, mem_addr, mem_wdata, mem_wmask, ld_conflict
  );

  modport slave (
    input  push, push_addr, push_data, push_size, mem_ack, ld_addr,
    output full, empty, count, overflow,
    output mem_req, mem_addr, mem_wdata, mem_wmask, ld_conflict
  );
endinterface

// File: rtl/store_commit_buffer.sv
// FIFO of retired stores drained to data memory over a req/ack handshake.
// Optional macro STORE_FWD_EN enables the combinational ld_conflict probe.
module store_commit_buffer #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64
) (
  input  logic                  clk,
  input  logic                  reset,
  store_commit_buffer_if.slave  bus
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);
  localparam int AW = ADDR_W - 3;

  typedef enum logic [0:0] {IDLE, REQ} state_e;

  state_e            state_q, state_d;
  logic [PW-1:0]     head_q, head_d;
  logic [PW-1:0]     tail_q, tail_d;
  logic [CW-1:0]     count_q, count_d;
  logic [DEPTH-1:0]  valid_q, valid_d;
  logic              overflow_q, overflow_d;

  logic [AW-1:0]     addr_q  [DEPTH];
  logic [DATA_W-1:0] wdata_q [DEPTH];
  logic [7:0]        mask_q  [DEPTH];

  logic              size_ok;
  logic              push_valid;
  logic              push_ok;
  logic              push_drop;
  logic              pop;
  logic              full_w;
  logic [2:0]        push_off;
  logic [7:0]        base_mask;
  logic [7:0]        push_mask;
  logic [DATA_W-1:0] push_wdata;

  assign full_w     = (count_q == CW'(DEPTH));
  assign push_valid = bus.push && size_ok;
  assign push_ok    = push_valid && !full_w;
  assign push_drop  = push_valid && full_w;
  assign pop        = (state_q == REQ) && bus.mem_ack;
  assign push_off   = bus.push_addr[2:0];

  // Lane encoding: lanes shifted past byte 7 fall off the 8-bit mask.
  always_comb begin
    // NOTE: every always_comb output is given a default first, so no path leaves it unassigned and infers a latch.
    size_ok   = 1'b1;
    base_mask = 8'h00;
    case (bus.push_size)
      4'd1:    base_mask = 8'h01;
      4'd2:    base_mask = 8'h03;
      4'd4:    base_mask = 8'h0F;
      4'd8:    base_mask = 8'hFF;
      default: size_ok   = 1'b0;
    endcase
    push_mask  = base_mask << push_off;
    push_wdata = bus.push_data << {push_off, 3'b000};
  end

  always_comb begin
    head_d     = head_q;
    tail_d     = tail_q;
    count_d    = count_q;
    valid_d    = valid_q;
    overflow_d = overflow_q;
    state_d    = state_q;

    if (push_ok) begin
      tail_d          = tail_q + PW'(1);
      valid_d[tail_q] = 1'b1;
    end
    if (pop) begin
      head_d          = head_q + PW'(1);
      valid_d[head_q] = 1'b0;
    end
    if (push_drop) begin
      overflow_d = 1'b1;
    end

    case ({push_ok, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase

    case (state_q)
      IDLE: begin
        if (count_q != '0) state_d = REQ;
      end
      REQ: begin
        if (pop && (count_d == '0)) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      valid_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      // NOTE: sequential state is updated with non-blocking assignments so every register samples pre-edge values.
      state_q    <= state_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      valid_q    <= valid_d;
      overflow_q <= overflow_d;
    end
  end

  // NOTE: entry payload has no reset; valid_q and the REQ state gate every read, so stale contents never escape.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      addr_q[tail_q]  <= bus.push_addr[ADDR_W-1:3];
      wdata_q[tail_q] <= push_wdata;
      mask_q[tail_q]  <= push_mask;
    end
  end

  // Memory outputs follow the registered state, so reset clears them immediately.
  always_comb begin
    bus.mem_req   = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    bus.mem_wmask = '0;
    if (state_q == REQ) begin
      bus.mem_req   = 1'b1;
      bus.mem_addr  = {addr_q[head_q], 3'b000};
      bus.mem_wdata = wdata_q[head_q];
      bus.mem_wmask = mask_q[head_q];
    end
  end

  assign bus.full     = full_w;
  assign bus.empty    = (count_q == '0);
  assign bus.count    = count_q;
  assign bus.overflow = overflow_q;

`ifdef STORE_FWD_EN
  logic ld_hit;

  always_comb begin
    ld_hit = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (valid_q[PW'(i)] && (addr_q[PW'(i)] == bus.ld_addr[ADDR_W-1:3]) && (mask_q[PW'(i)] != 8'h00))
        ld_hit = 1'b1;
    end
  end

  assign bus.ld_conflict = ld_hit;
`else
  logic unused_ld_addr;

  assign unused_ld_addr  = ^bus.ld_addr;
  assign bus.ld_conflict = 1'b0;
`endif

endmodule

// File: tb/tb_store_commit_buffer.sv
// Self-checking bench for store_commit_buffer: directed test-plan steps followed by
// random traffic, all compared against a queue-based reference model.
module tb_store_commit_buffer;

  localparam int DEPTH  = 4;
  localparam int ADDR_W = 64;
  localparam int DATA_W = 64;

  typedef struct {
    logic [60:0] dw;
    logic [63:0] wdata;
    logic [7:0]  mask;
  } ent_t;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  ent_t q[$];
  logic ovf_m;
  logic req_m;

  store_commit_buffer_if #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  store_commit_buffer #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic conflict_m(input logic [63:0] la);
    logic hit;
    hit = 1'b0;
`ifdef STORE_FWD_EN
    foreach (q[i]) if (q[i].dw == la[63:3] && q[i].mask != 8'h00) hit = 1'b1;
`endif
    return hit;
  endfunction

  task automatic model_reset();
    q.delete();
    ovf_m = 1'b0;
    req_m = 1'b0;
  endtask

  // Applies one clock edge worth of buffer rules to the model.
  task automatic model_step(input logic p, input logic [63:0] a, input logic [63:0] d,
                            input logic [3:0] s, input logic ack);
    int          pre_cnt;
    logic        vpush;
    logic        popped;
    logic [15:0] m;
    logic [127:0] wide;
    ent_t        e;
    pre_cnt = q.size();
    vpush   = p && (s == 4'd1 || s == 4'd2 || s == 4'd4 || s == 4'd8);
    popped  = req_m && ack;
    if (vpush) begin
      if (pre_cnt == DEPTH) begin
        ovf_m = 1'b1;
      end else begin
        m       = ((16'd1 << s) - 16'd1) << a[2:0];
        wide    = {64'd0, d} << (8 * a[2:0]);
        e.dw    = a[63:3];
        e.mask  = m[7:0];
        e.wdata = wide[63:0];
        q.push_back(e);
      end
    end
    if (popped) void'(q.pop_front());
    if (!req_m) req_m = (pre_cnt > 0);
    else if (popped) req_m = (q.size() > 0);
  endtask

  task automatic check_all(input logic [63:0] la);
    check("count", 64'(bus.count), 64'(q.size()));
    check("full", 64'(bus.full), 64'(q.size() == DEPTH));
    check("empty", 64'(bus.empty), 64'(q.size() == 0));
    check("overflow", 64'(bus.overflow), 64'(ovf_m));
    check("mem_req", 64'(bus.mem_req), 64'(req_m));
    if (req_m) begin
      check("mem_addr", bus.mem_addr, {q[0].dw, 3'b000});
      check("mem_wdata", bus.mem_wdata, q[0].wdata);
      check("mem_wmask", 64'(bus.mem_wmask), 64'(q[0].mask));
    end else begin
      check("mem_addr_idle", bus.mem_addr, 64'd0);
      check("mem_wdata_idle", bus.mem_wdata, 64'd0);
      check("mem_wmask_idle", 64'(bus.mem_wmask), 64'd0);
    end
    check("ld_conflict", 64'(bus.ld_conflict), 64'(conflict_m(la)));
  endtask

  task automatic cycle(input logic p, input logic [63:0] a, input logic [63:0] d,
                       input logic [3:0] s, input logic ack, input logic [63:0] la);
    bus.push      = p;
    bus.push_addr = a;
    bus.push_data = d;
    bus.push_size = s;
    bus.mem_ack   = ack;
    bus.ld_addr   = la;
    @(posedge clk);
    model_step(p, a, d, s, ack);
    #1;
    check_all(la);
  endtask

  task automatic idle(input logic ack);
    cycle(1'b0, 64'd0, 64'd0, 4'd0, ack, 64'd0);
  endtask

  initial begin
    logic [3:0]  sz;
    logic [63:0] la;
    checks = 0;
    errors = 0;
    model_reset();
    reset         = 1'b1;
    bus.push      = 1'b0;
    bus.push_addr = '0;
    bus.push_data = '0;
    bus.push_size = '0;
    bus.mem_ack   = 1'b0;
    bus.ld_addr   = '0;
    #3;
    check_all(64'd0);
    @(negedge clk);
    reset = 1'b0;

    // Single byte store at a misaligned lane.
    cycle(1'b1, 64'h1003, 64'hAB, 4'd1, 1'b0, 64'd0);
    check("single_req_latency", 64'(bus.mem_req), 64'd0);
    idle(1'b0);
    check("single_req", 64'(bus.mem_req), 64'd1);
    check("single_addr", bus.mem_addr, 64'h1000);
    check("single_mask", 64'(bus.mem_wmask), 64'h08);
    check("single_wdata", bus.mem_wdata, 64'hAB00_0000);
    idle(1'b1);
    check("single_empty", 64'(bus.empty), 64'd1);
    idle(1'b0);

    // Fill, overflow, then drain in order.
    for (int i = 0; i < DEPTH; i++)
      cycle(1'b1, 64'h4000 + 64'(8 * i), 64'h1111 * 64'(i + 1), 4'd8, 1'b0, 64'd0);
    check("fill_full", 64'(bus.full), 64'd1);
    check("fill_count", 64'(bus.count), 64'd4);
    cycle(1'b1, 64'h5000, 64'hDEAD, 4'd8, 1'b0, 64'd0);
    check("fill_overflow", 64'(bus.overflow), 64'd1);
    check("fill_count_hold", 64'(bus.count), 64'd4);
    idle(1'b1);
    check("drain_full_drop", 64'(bus.full), 64'd0);
    for (int i = 0; i < DEPTH - 1; i++) idle(1'b1);
    idle(1'b0);

    // Push and pop in the same cycle with two entries pending.
    reset = 1'b1;
    #1;
    model_reset();
    reset = 1'b0;
    cycle(1'b1, 64'h6000, 64'h1, 4'd8, 1'b0, 64'd0);
    cycle(1'b1, 64'h6008, 64'h2, 4'd8, 1'b0, 64'd0);
    cycle(1'b1, 64'h6010, 64'h3, 4'd8, 1'b1, 64'd0);
    check("pushpop_count", 64'(bus.count), 64'd2);
    check("pushpop_next", bus.mem_addr, 64'h6008);
    idle(1'b1);
    idle(1'b1);
    idle(1'b0);

    // Misaligned word and an invalid size.
    cycle(1'b1, 64'h2006, 64'hCAFE_BABE, 4'd4, 1'b0, 64'd0);
    idle(1'b0);
    check("misalign_mask", 64'(bus.mem_wmask), 64'hC0);
    cycle(1'b1, 64'h2100, 64'h77, 4'd3, 1'b0, 64'd0);
    check("bad_size_count", 64'(bus.count), 64'd1);
    check("bad_size_ovf", 64'(bus.overflow), 64'd0);

    // Asynchronous reset while a request is pending.
    check("pre_reset_req", 64'(bus.mem_req), 64'd1);
    @(negedge clk);
    reset = 1'b1;
    #1;
    model_reset();
    check("async_req", 64'(bus.mem_req), 64'd0);
    check("async_count", 64'(bus.count), 64'd0);
    check("async_empty", 64'(bus.empty), 64'd1);
    @(negedge clk);
    reset = 1'b0;

`ifdef STORE_FWD_EN
    cycle(1'b1, 64'h3008, 64'h5A, 4'd8, 1'b0, 64'h300C);
    check("fwd_hit", 64'(bus.ld_conflict), 64'd1);
    bus.ld_addr = 64'h3010;
    #1;
    check("fwd_miss", 64'(bus.ld_conflict), 64'd0);
    cycle(1'b0, 64'd0, 64'd0, 4'd0, 1'b0, 64'h300C);
    check("fwd_hit_req", 64'(bus.ld_conflict), 64'd1);
    cycle(1'b0, 64'd0, 64'd0, 4'd0, 1'b1, 64'h300C);
    check("fwd_popped", 64'(bus.ld_conflict), 64'd0);
`endif

    // Random traffic over a small address window so conflicts and wraps are frequent.
    for (int n = 0; n < 400; n++) begin
      case ($urandom_range(0, 11))
        0, 1:    sz = 4'd1;
        2, 3:    sz = 4'd2;
        4, 5:    sz = 4'd4;
        6, 7, 8: sz = 4'd8;
        9:       sz = 4'd3;
        10:      sz = 4'd0;
        default: sz = 4'd15;
      endcase
      la = 64'h3000 + 64'($urandom_range(0, 63));
      cycle(($urandom_range(0, 9) < 6), 64'h3000 + 64'($urandom_range(0, 63)),
            {$urandom, $urandom}, sz, ($urandom_range(0, 1) == 1), la);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/store_commit_buffer.md
Name: store_commit_buffer

Overview:
- Sits directly downstream of the retire stage.
- Accepts architecturally committed stores (address, data, size) at the cycle they retire and queues them in a FIFO.
- Drains the FIFO to data memory one store at a time over a req/ack handshake.
- Back-pressures retire through `full`, which drives retire_stall.

Parameters:
- DEPTH, 4, number of buffered stores (power of two, >=2)
- ADDR_W, 64, address width
- DATA_W, 64, store data width (one doubleword)

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- push  in  1  retire is committing a store this cycle (lsq_decrement qualified)
- push_addr  in  ADDR_W  store byte address
- push_data  in  DATA_W  store value, right-aligned
- push_size  in  4  bytes stored: 1/2/4/8; any other value is not a store
- full  out  1  count==DEPTH; wired to retire_stall
- empty  out  1  count==0
- count  out  $clog2(DEPTH+1)  occupied entries
- overflow  out  1  sticky: a valid push was dropped
- mem_req  out  1  write request valid
- mem_addr  out  ADDR_W  head address with bits [2:0] forced to 0
- mem_wdata  out  DATA_W  head data shifted into byte lanes
- mem_wmask  out  8  byte-lane enables
- mem_ack  in  1  memory accepted the write this cycle
- ld_addr  in  ADDR_W  load address to check (STORE_FWD_EN only)
- ld_conflict  out  1  pending store overlaps ld_addr doubleword

Behaviour:
- Reset (async, active-high): all entries invalid, head=tail=0, count=0, state IDLE.
- Reset output values: mem_req=0, mem_addr=0, mem_wdata=0, mem_wmask=0, overflow=0, full=0, empty=1, ld_conflict=0.
- A reset asserted while a request is pending drops mem_req in the same cycle; the in-flight store is lost by definition.
- Push acceptance:
  - A push is valid when push=1 and push_size is in {1,2,4,8}; otherwise it is ignored.
  - A valid push when count<DEPTH writes the tail entry at the clock edge; tail increments mod DEPTH.
- Lane encoding, computed at push time and stored in the entry:
  - off = push_addr[2:0]
  - mask = ((1<<size)-1) << off, truncated to 8 bits; misaligned bytes beyond lane 7 are discarded, with no fault.
  - wdata = push_data << (8*off), truncated to DATA_W.
- Full:
  - A valid push when count==DEPTH is dropped and sets overflow=1 until reset.
  - This holds even if a pop occurs in the same cycle; full is registered-state based, so retire must have stalled.
- FSM with states IDLE and REQ:
  - IDLE: mem_req=0. If count>0, go to REQ next cycle.
  - REQ: mem_req=1; mem_addr/mem_wdata/mem_wmask driven from the head entry and held stable until ack.
  - REQ with mem_ack=1: pop the head (head increments mod DEPTH). If post-pop count>0, stay in REQ with the next head presented the following cycle; else go to IDLE.
  - mem_ack while in IDLE is ignored.
- Latency: a push at edge N makes mem_req=1 from cycle N+1 at the earliest (IDLE->REQ at edge N+1, req visible after N+1). Back-to-back acks drain one store per cycle.
- Simultaneous push and pop with 0<count<DEPTH: both occur; count is unchanged.
- Push to an empty buffer while in IDLE: the entry is written; the request starts the cycle after.
- Pointers wrap mod DEPTH; count distinguishes full from empty.
- No flush input: every retired store is committed and must reach memory. A pipeline flush never drains or drops entries.
- Stores to the same address drain in program (FIFO) order.

Optional Feature:
- Macro: STORE_FWD_EN
- Defined: ld_conflict is combinational.
  - ld_conflict=1 if any valid entry has addr[ADDR_W-1:3]==ld_addr[ADDR_W-1:3] and a nonzero mask.
  - Conflicting entries include the head entry currently in REQ; the load unit uses this to stall the load.
- Undefined: ld_addr is unused and ld_conflict is tied to 0.

Test Plan:
- Single store: push addr=0x1003, data=0xAB, size=1 -> next cycle mem_req=1, mem_addr=0x1000, mem_wmask=0x08, mem_wdata=0xAB000000; ack -> empty=1 next cycle.
- Fill and stall: DEPTH=4, 4 pushes with mem_ack=0 -> full=1, count=4. A 5th push -> overflow=1, count stays 4. Then ack x4 -> data emerges in push order, full drops after the first ack.
- Push and pop together: count=2, push + ack in the same cycle -> count=2, next mem_addr is the second-oldest entry. Wrap verified after 10 total stores.
- Misaligned and invalid size: push addr=0x2006, size=4 -> mem_wmask=0xC0. A push with size=3 is ignored: count unchanged, overflow=0.
- Reset mid-request: mem_req=1, assert reset asynchronously -> mem_req=0, count=0, empty=1 before the next edge.
- STORE_FWD_EN: pending store to 0x3008; ld_addr=0x300C -> ld_conflict=1; ld_addr=0x3010 -> 0. After the ack pops that store, ld_addr=0x300C -> 0.
